// File: rtl/phase_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phase_cmd_sequencer
// Purpose  : Host byte-stream command parser with double-buffered phase,
//            calibration and enable registers, committed at a PWM period edge.
// Revision : 1.0
// ============================================================================
module phase_cmd_sequencer #(
    parameter int NUM_CHANNELS = 4,
    parameter int PHASE_WIDTH  = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_rxfifo_empty,
    input  logic [7:0]                          i_rxfifo_data,
    output logic                                o_rxfifo_rd,
    input  logic                                i_period_start,
    output logic [NUM_CHANNELS*PHASE_WIDTH-1:0] o_phase,
    output logic [NUM_CHANNELS*PHASE_WIDTH-1:0] o_phase_calibration,
    output logic [NUM_CHANNELS-1:0]             o_pwm_en,
    output logic                                o_commit_done,
    output logic                                o_cmd_error,
    output logic                                o_busy
);

    localparam int         c_VEC_W     = NUM_CHANNELS * PHASE_WIDTH;
    localparam logic [1:0] c_OP_PHASE  = 2'b00;
    localparam logic [1:0] c_OP_CAL    = 2'b01;
    localparam logic [1:0] c_OP_EN     = 2'b10;
    localparam logic [1:0] c_OP_COMMIT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_PAYLOAD     = 2'd1,
        S_COMMIT_WAIT = 2'd2
    } state_t;

    state_t                    r_state;
    logic [1:0]                r_opcode;
    logic [5:0]                r_addr;
    logic [c_VEC_W-1:0]        r_shadow_phase;
    logic [c_VEC_W-1:0]        r_shadow_cal;
    logic [NUM_CHANNELS-1:0]   r_shadow_en;
    logic [c_VEC_W-1:0]        r_active_phase;
    logic [c_VEC_W-1:0]        r_active_cal;
    logic [NUM_CHANNELS-1:0]   r_active_en;
    logic                      r_commit_done;
    logic                      r_cmd_error;
    logic                      r_busy;
    logic                      w_pop;
    logic                      w_addr_valid;

    // The FIFO is FWFT, so popping is just a matter of being in a byte-accepting state.
    assign w_pop        = ((r_state == S_IDLE) || (r_state == S_PAYLOAD)) && !i_rxfifo_empty;
    assign w_addr_valid = (r_addr < 6'(NUM_CHANNELS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_opcode       <= 2'b00;
            r_addr         <= 6'd0;
            r_shadow_phase <= '0;
            r_shadow_cal   <= '0;
            r_shadow_en    <= '0;
            r_active_phase <= '0;
            r_active_cal   <= '0;
            r_active_en    <= '0;
            r_commit_done  <= 1'b0;
            r_cmd_error    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_commit_done <= 1'b0;
            r_cmd_error   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_busy <= 1'b1;
                        if (i_rxfifo_data[7:6] == c_OP_COMMIT) begin
                            r_state <= S_COMMIT_WAIT;
                        end else begin
                            r_state  <= S_PAYLOAD;
                            r_opcode <= i_rxfifo_data[7:6];
                            r_addr   <= i_rxfifo_data[5:0];
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_pop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (r_opcode == c_OP_EN) begin
                            r_shadow_en <= i_rxfifo_data[NUM_CHANNELS-1:0];
                        end else if (!w_addr_valid) begin
                            r_cmd_error <= 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_CHANNELS; i++) begin
                                if (r_addr == 6'(i)) begin
                                    if (r_opcode == c_OP_PHASE)
                                        r_shadow_phase[i*PHASE_WIDTH +: PHASE_WIDTH] <= i_rxfifo_data[PHASE_WIDTH-1:0];
                                    else if (r_opcode == c_OP_CAL)
                                        r_shadow_cal[i*PHASE_WIDTH +: PHASE_WIDTH] <= i_rxfifo_data[PHASE_WIDTH-1:0];
                                end
                            end
                        end
                    end
                end
                S_COMMIT_WAIT: begin
                    // All three banks move together so every channel switches on one carrier edge.
                    if (i_period_start) begin
                        r_active_phase <= r_shadow_phase;
                        r_active_cal   <= r_shadow_cal;
                        r_active_en    <= r_shadow_en;
                        r_commit_done  <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rxfifo_rd         = w_pop;
    assign o_phase             = r_active_phase;
    assign o_phase_calibration = r_active_cal;
    assign o_pwm_en            = r_active_en;
    assign o_commit_done       = r_commit_done;
    assign o_cmd_error         = r_cmd_error;
    assign o_busy              = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_phase_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_cmd_sequencer
// Purpose  : Self-checking bench: FWFT FIFO model plus protocol-level reference.
// Revision : 1.0
// ============================================================================
module tb_phase_cmd_sequencer;

    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_rxfifo_empty = 1'b1;
    logic [7:0]       i_rxfifo_data = 8'h00;
    logic             o_rxfifo_rd;
    logic             i_period_start = 1'b0;
    logic [NCH*8-1:0] o_phase;
    logic [NCH*8-1:0] o_phase_calibration;
    logic [NCH-1:0]   o_pwm_en;
    logic             o_commit_done;
    logic             o_cmd_error;
    logic             o_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    logic [7:0] q[$];

    // reference model: pending header byte, commit armed flag, shadow/active banks
    bit         m_have_hdr;
    logic [7:0] m_hdr;
    bit         m_armed;
    logic [7:0] m_sh_ph[NCH], m_sh_cal[NCH], m_act_ph[NCH], m_act_cal[NCH];
    logic [NCH-1:0] m_sh_en, m_act_en;
    bit         m_done, m_err;

    phase_cmd_sequencer #(.NUM_CHANNELS(NCH), .PHASE_WIDTH(8)) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_rxfifo_empty      (i_rxfifo_empty),
        .i_rxfifo_data       (i_rxfifo_data),
        .o_rxfifo_rd         (o_rxfifo_rd),
        .i_period_start      (i_period_start),
        .o_phase             (o_phase),
        .o_phase_calibration (o_phase_calibration),
        .o_pwm_en            (o_pwm_en),
        .o_commit_done       (o_commit_done),
        .o_cmd_error         (o_cmd_error),
        .o_busy              (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have_hdr = 0; m_hdr = 8'h00; m_armed = 0; m_done = 0; m_err = 0;
        m_sh_en = '0; m_act_en = '0;
        for (int i = 0; i < NCH; i++) begin
            m_sh_ph[i] = 8'h00; m_sh_cal[i] = 8'h00; m_act_ph[i] = 8'h00; m_act_cal[i] = 8'h00;
        end
    endtask

    function automatic logic [NCH*8-1:0] pack(input logic [7:0] a[NCH]);
        logic [NCH*8-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*8 +: 8] = a[i];
        return v;
    endfunction

    task automatic model_step(input bit popped, input logic [7:0] b, input bit ps);
        int addr;
        m_done = 0; m_err = 0;
        if (m_armed) begin
            if (ps) begin
                m_act_ph = m_sh_ph; m_act_cal = m_sh_cal; m_act_en = m_sh_en;
                m_done = 1; m_armed = 0;
            end
        end else if (popped) begin
            if (!m_have_hdr) begin
                if (b[7:6] == 2'b11) m_armed = 1;
                else begin m_have_hdr = 1; m_hdr = b; end
            end else begin
                addr = int'(m_hdr[5:0]);
                case (m_hdr[7:6])
                    2'b10: m_sh_en = b[NCH-1:0];
                    2'b00: if (addr < NCH) m_sh_ph[addr] = b; else m_err = 1;
                    default: if (addr < NCH) m_sh_cal[addr] = b; else m_err = 1;
                endcase
                m_have_hdr = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("phase",     64'(o_phase),             64'(pack(m_act_ph)));
        chk("cal",       64'(o_phase_calibration), 64'(pack(m_act_cal)));
        chk("pwm_en",    64'(o_pwm_en),            64'(m_act_en));
        chk("commit",    64'(o_commit_done),       64'(m_done));
        chk("cmd_error", 64'(o_cmd_error),         64'(m_err));
        chk("busy",      64'(o_busy),              64'(m_have_hdr || m_armed));
    endtask

    task automatic tick(input bit ps);
        bit         popped;
        logic [7:0] b;
        @(negedge clk);
        i_period_start = ps;
        i_rxfifo_empty = (q.size() == 0);
        i_rxfifo_data  = (q.size() == 0) ? 8'h00 : q[0];
        #1;
        chk("rxfifo_rd", 64'(o_rxfifo_rd), 64'(!m_armed && q.size() > 0));
        popped = o_rxfifo_rd && (q.size() > 0);
        b = popped ? q[0] : 8'h00;
        @(posedge clk);
        model_step(popped, b, ps);
        if (popped) begin void'(q.pop_front()); n_pops++; end
        #1;
        check_outputs();
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (q.size() > 0 && n < max_cycles) begin tick(1'b0); n++; end
        if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        model_reset();
        i_rxfifo_empty = 1'b1; i_period_start = 1'b0;
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pops_before;
        model_reset();
        apply_reset();
        tick(1'b0);

        // atomic update: nothing moves until period_start
        q.push_back(8'h00); q.push_back(8'h40);
        q.push_back(8'h03); q.push_back(8'hC0);
        q.push_back(8'h80); q.push_back(8'h0F);
        q.push_back(8'hC0);
        drain(50);
        repeat (3) tick(1'b0);
        chk("pre_commit_phase", 64'(o_phase), 64'd0);
        tick(1'b1);
        chk("atomic_ph0", 64'(o_phase[7:0]), 64'h40);
        chk("atomic_ph3", 64'(o_phase[31:24]), 64'hC0);
        chk("atomic_en", 64'(o_pwm_en), 64'hF);
        chk("atomic_done", 64'(o_commit_done), 64'd1);
        tick(1'b0);

        // calibration on channel 2
        q.push_back(8'h42); q.push_back(8'h25); q.push_back(8'hC0);
        drain(20);
        tick(1'b1);
        chk("cal_ch2", 64'(o_phase_calibration[23:16]), 64'h25);
        chk("cal_other", 64'({o_phase_calibration[31:24], o_phase_calibration[15:0]}), 64'd0);

        // invalid address, then a valid header right behind it
        q.push_back(8'h05); q.push_back(8'h77);
        q.push_back(8'h01); q.push_back(8'h99); q.push_back(8'hC0);
        tick(1'b0); tick(1'b0);
        chk("inv_err", 64'(o_cmd_error), 64'd1);
        drain(20);
        tick(1'b1);
        chk("after_inv_ph1", 64'(o_phase[15:8]), 64'h99);

        // COMMIT pop coincides with period_start; more bytes queued behind it
        q.push_back(8'hC0); q.push_back(8'h01); q.push_back(8'h11);
        tick(1'b1);
        pops_before = n_pops;
        repeat (4) tick(1'b0);
        chk("stall_pops", 64'(n_pops - pops_before), 64'd0);
        chk("stall_no_commit", 64'(o_commit_done), 64'd0);
        tick(1'b1);
        chk("stall_commit", 64'(o_commit_done), 64'd1);
        drain(20);

        // reset mid-PAYLOAD, then the next byte must be a header
        q.push_back(8'h01);
        tick(1'b0);
        chk("mid_payload_busy", 64'(o_busy), 64'd1);
        apply_reset();
        q.push_back(8'h40); q.push_back(8'h33); q.push_back(8'hC0);
        drain(20);
        tick(1'b1);
        chk("post_reset_cal0", 64'(o_phase_calibration[7:0]), 64'h33);
        chk("post_reset_ph", 64'(o_phase), 64'd0);

        // back-to-back: 8 commands, FIFO never empty
        pops_before = n_pops;
        for (int i = 0; i < 8; i++) begin
            q.push_back(8'((i % 2) << 6 | (i % NCH)));
            q.push_back(8'($urandom_range(0, 255)));
        end
        q.push_back(8'hC0);
        repeat (17) tick(1'b0);
        chk("b2b_pops", 64'(n_pops - pops_before), 64'd17);
        tick(1'b1);
        tick(1'b0);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 9) < 3 && q.size() < 16) begin
                logic [7:0] h;
                h = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
                q.push_back(h);
                if (h[7:6] != 2'b11) q.push_back(8'($urandom_range(0, 255)));
            end
            tick($urandom_range(0, 7) == 0);
        end
        q.push_back(8'hC0);
        for (int c = 0; c < 200 && (q.size() > 0 || m_armed || m_have_hdr); c++)
            tick((c % 5) == 4);
        chk("final_idle", 64'(o_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
